// File: rtl/ascii_uart_tx.sv
// rtl/ascii_uart_tx.sv - buffered UART transmitter for the ASCII message stream.
// Characters queue in a small FIFO and leave LSB first with optional parity and 1/2 stop bits.
module ascii_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            push, pop, fifo_empty, baud_done;
  logic [7:0]      head;

  assign in_ready   = (count_q < CW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign baud_done  = (baud_q == BAUD_LAST);
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign fifo_count = count_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        pop    = !fifo_empty;
      end
      START: if (baud_done) begin
        state_d = DATA;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
      end
      DATA: if (baud_done) begin
        baud_d = '0;
        if (bit_q == 3'd7) begin
          bit_d = '0;
          if (PARITY_EN != 0) begin
            state_d = PARITY;
            tx_d    = par_q;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          bit_d   = bit_q + 3'd1;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      PARITY: if (baud_done) begin
        state_d = STOP;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
      STOP: if (baud_done) begin
        baud_d = '0;
        // bit_q doubles as the stop-bit counter here
        if (bit_q == STOP_LAST) begin
          if (!fifo_empty) pop = 1'b1;
          else state_d = IDLE;
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      state_d = START;
      baud_d  = '0;
      shift_d = head;
      par_d   = (^head) ^ (PARITY_ODD != 0);
      tx_d    = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end
endmodule
